// File: rtl/ysyx_23060236_mdu_pkg.sv
// Shared M-extension opcode encodings, FSM states and operand signedness decode
// for the multiply/divide unit.
package ysyx_23060236_mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_t;

  // Returns {src1_signed, src2_signed} for an opcode.
  function automatic logic [1:0] operand_signs(input logic [2:0] f);
    logic [1:0] s;
    case (f)
      MDU_MUL:    s = 2'b00;
      MDU_MULH:   s = 2'b11;
      MDU_MULHSU: s = 2'b10;
      MDU_MULHU:  s = 2'b00;
      MDU_DIV:    s = 2'b11;
      MDU_DIVU:   s = 2'b00;
      MDU_REM:    s = 2'b11;
      MDU_REMU:   s = 2'b00;
      default:    s = 2'b00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ysyx_23060236_mdu_div.sv
// Restoring radix-2 divider on unsigned magnitudes. Also owns the step counter
// that paces every iterative operation of the unit.
module ysyx_23060236_mdu_div #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            start,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            last
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dsr;
  logic [CW-1:0]   count;
  logic [XLEN:0]   trial;

  // quotient/remainder are the values after the current step, so the caller
  // can finish the operation on the same edge as the last step.
  always_comb begin
    trial = {rem, quo[XLEN-1]} - {1'b0, dsr};
    if (trial[XLEN]) begin
      remainder = {rem[XLEN-2:0], quo[XLEN-1]};
      quotient  = {quo[XLEN-2:0], 1'b0};
    end else begin
      remainder = trial[XLEN-1:0];
      quotient  = {quo[XLEN-2:0], 1'b1};
    end
  end

  assign last = (count == CW'(XLEN - 1));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      rem   <= '0;
      quo   <= '0;
      dsr   <= '0;
      count <= '0;
    end else if (start) begin
      rem   <= '0;
      quo   <= dividend;
      dsr   <= divisor;
      count <= '0;
    end else if (step) begin
      rem   <= remainder;
      quo   <= quotient;
      count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_23060236_mdu.sv
// Iterative RV M-extension multiply/divide unit with valid/ready handshakes,
// flush, and result hold until the consumer accepts it.
module ysyx_23060236_mdu
  import ysyx_23060236_mdu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit MUL_FAST = 1'b0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  mdu_state_t        state;
  logic [2:0]        op;
  logic              neg;
  logic [XLEN-1:0]   mcand;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] fast_prod;

  logic [1:0]        signs;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              is_rem;
  logic              div_by_zero;
  logic              div_overflow;
  logic              accept;

  logic [XLEN-1:0]   div_quo;
  logic [XLEN-1:0]   div_rem;
  logic              div_last;

  function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] mag,
                                               input logic negate, input logic high);
    logic [2*XLEN-1:0] p;
    p = negate ? -mag : mag;
    return high ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
  endfunction

  function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] v, input logic negate);
    return negate ? -v : v;
  endfunction

  assign in_ready     = (state == MDU_IDLE);
  assign accept       = in_valid && in_ready && !flush;
  assign signs        = operand_signs(funct3);
  assign a_neg        = signs[1] && src1[XLEN-1];
  assign b_neg        = signs[0] && src2[XLEN-1];
  assign mag_a        = a_neg ? -src1 : src1;
  assign mag_b        = b_neg ? -src2 : src2;
  assign is_rem       = (funct3 == MDU_REM) || (funct3 == MDU_REMU);
  assign div_by_zero  = (src2 == '0);
  assign div_overflow = ((funct3 == MDU_DIV) || (funct3 == MDU_REM)) &&
                        (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);
  assign fast_prod    = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};

  // Shift-add step: the multiplier sits in the low half and is consumed LSB first.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mcand};
    acc_next = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
  end

  ysyx_23060236_mdu_div #(.XLEN(XLEN)) u_div (
    .clock     (clock),
    .reset     (reset),
    .clear     (flush),
    .start     (accept),
    .step      (state == MDU_BUSY),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (div_quo),
    .remainder (div_rem),
    .last      (div_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= MDU_IDLE;
      op        <= '0;
      neg       <= 1'b0;
      mcand     <= '0;
      acc       <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= MDU_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (in_valid) begin
            op    <= funct3;
            neg   <= is_rem ? a_neg : (a_neg ^ b_neg);
            mcand <= mag_a;
            acc   <= {{XLEN{1'b0}}, mag_b};
            if (funct3[2] && div_by_zero) begin
              result    <= funct3[1] ? src1 : '1;
              out_valid <= 1'b1;
              state     <= MDU_DONE;
            end else if (funct3[2] && div_overflow) begin
              result    <= funct3[1] ? '0 : src1;
              out_valid <= 1'b1;
              state     <= MDU_DONE;
            end else if (!funct3[2] && MUL_FAST) begin
              result    <= mul_pick(fast_prod, a_neg ^ b_neg, funct3 != MDU_MUL);
              out_valid <= 1'b1;
              state     <= MDU_DONE;
            end else begin
              state <= MDU_BUSY;
            end
          end
        end
        MDU_BUSY: begin
          acc <= acc_next;
          if (div_last) begin
            if (!op[2])
              result <= mul_pick(acc_next, neg, op != MDU_MUL);
            else if (op[1])
              result <= apply_sign(div_rem, neg);
            else
              result <= apply_sign(div_quo, neg);
            out_valid <= 1'b1;
            state     <= MDU_DONE;
          end
        end
        MDU_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= MDU_IDLE;
          end
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060236_mdu.sv
// Scoreboard bench for the MDU: one 32-bit iterative-multiply instance and one
// 16-bit fast-multiply instance, exercised in turn through shared tasks.
module tb_ysyx_23060236_mdu;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  funct3 = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_valid_32 = 1'b0;
  logic        in_valid_16 = 1'b0;
  logic [31:0] src1_32 = '0, src2_32 = '0;
  logic [15:0] src1_16 = '0, src2_16 = '0;
  logic        in_ready_32, out_valid_32, in_ready_16, out_valid_16;
  logic [31:0] result_32;
  logic [15:0] result_16;

  int errors = 0;
  int checks = 0;
  int cur_x = 32;

  typedef struct {
    logic [31:0] value;
    int          lat;
    string       name;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;

  ysyx_23060236_mdu #(.XLEN(32), .MUL_FAST(1'b0)) dut32 (
    .clock(clock), .reset(reset), .in_valid(in_valid_32), .in_ready(in_ready_32),
    .funct3(funct3), .src1(src1_32), .src2(src2_32), .flush(flush),
    .out_valid(out_valid_32), .out_ready(out_ready), .result(result_32)
  );

  ysyx_23060236_mdu #(.XLEN(16), .MUL_FAST(1'b1)) dut16 (
    .clock(clock), .reset(reset), .in_valid(in_valid_16), .in_ready(in_ready_16),
    .funct3(funct3), .src1(src1_16), .src2(src2_16), .flush(flush),
    .out_valid(out_valid_16), .out_ready(out_ready), .result(result_16)
  );

  function automatic logic ov();
    return (cur_x == 32) ? out_valid_32 : out_valid_16;
  endfunction

  function automatic logic ir();
    return (cur_x == 32) ? in_ready_32 : in_ready_16;
  endfunction

  function automatic logic [31:0] res();
    return (cur_x == 32) ? result_32 : {16'h0, result_16};
  endfunction

  // Reference result from wide integer arithmetic at the current width.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint unsigned mask, ua, ub, minv;
    longint sa, sb, r;
    logic [63:0] t;
    mask = (cur_x == 32) ? 64'hFFFF_FFFF : 64'hFFFF;
    ua   = {32'h0, a} & mask;
    ub   = {32'h0, b} & mask;
    minv = 64'd1 << (cur_x - 1);
    sa   = ((ua & minv) != 0) ? longint'(ua) - longint'(mask) - 1 : longint'(ua);
    sb   = ((ub & minv) != 0) ? longint'(ub) - longint'(mask) - 1 : longint'(ub);
    case (f)
      3'd0:    r = sa * sb;
      3'd1:    r = (sa * sb) >>> cur_x;
      3'd2:    r = (sa * longint'(ub)) >>> cur_x;
      3'd3:    r = longint'((ua * ub) >> cur_x);
      3'd4:    r = (ub == 0) ? -1 : ((ua == minv && ub == mask) ? sa : sa / sb);
      3'd5:    r = (ub == 0) ? -1 : longint'(ua / ub);
      3'd6:    r = (ub == 0) ? sa : ((ua == minv && ub == mask) ? 0 : sa % sb);
      default: r = (ub == 0) ? longint'(ua) : longint'(ua % ub);
    endcase
    t = r;
    t = t & mask;
    return t[31:0];
  endfunction

  // Cycles from the accept cycle to the first cycle showing out_valid.
  function automatic int lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] m, ua, ub, minv;
    m    = (cur_x == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    ua   = a & m;
    ub   = b & m;
    minv = 32'd1 << (cur_x - 1);
    if (f[2]) begin
      if (ub == 0) return 1;
      if ((f == 3'd4 || f == 3'd6) && ua == minv && ub == m) return 1;
      return cur_x + 1;
    end
    return (cur_x == 16) ? 1 : cur_x + 1;
  endfunction

  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!ir() && n < 100) begin
      @(posedge clock); #1; n++;
    end
    checks++;
    if (ir() !== 1'b1) begin
      errors++;
      $display("FAIL start_x%0d: in_ready got %b required 1 within 100 cycles", cur_x, ir());
    end
    funct3  = f;
    src1_32 = a;
    src2_32 = b;
    src1_16 = a[15:0];
    src2_16 = b[15:0];
    if (cur_x == 32) in_valid_32 = 1'b1;
    else             in_valid_16 = 1'b1;
    @(posedge clock); #1;
    in_valid_32 = 1'b0;
    in_valid_16 = 1'b0;
  endtask

  task automatic issue(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expv);
    exp_t e;
    start_op(f, a, b);
    e.value = expv;
    e.lat   = lat_of(f, a, b);
    e.name  = name;
    sb.push_back(e);
  endtask

  task automatic collect();
    exp_t e;
    int cyc = 1;
    e = sb.pop_front();
    while (!ov() && cyc < 200) begin
      @(posedge clock); #1; cyc++;
    end
    checks++;
    if (ov() !== 1'b1) begin
      errors++;
      $display("FAIL %s_x%0d timeout: out_valid got %b required 1 within 200 cycles", e.name, cur_x, ov());
    end else begin
      checks++;
      if (cyc !== e.lat) begin
        errors++;
        $display("FAIL %s_x%0d latency: got %0d cycles required %0d", e.name, cur_x, cyc, e.lat);
      end
      checks++;
      if (res() !== e.value) begin
        errors++;
        $display("FAIL %s_x%0d result: got %h required %h", e.name, cur_x, res(), e.value);
      end
    end
    $display("x%0d %s result=%h latency=%0d", cur_x, e.name, res(), cyc);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    checks++;
    if (ir() !== 1'b1 || ov() !== 1'b0) begin
      errors++;
      $display("FAIL %s_x%0d release: in_ready/out_valid got %b/%b required 1/0", e.name, cur_x, ir(), ov());
    end
  endtask

  task automatic issue_m(input string name, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    issue(name, f, a, b, model(f, a, b));
    collect();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    for (int w = 0; w < 2; w++) begin
      cur_x = (w == 0) ? 32 : 16;
      checks++;
      if (ir() !== 1'b1 || ov() !== 1'b0 || res() !== 32'h0) begin
        errors++;
        $display("FAIL reset_x%0d: in_ready/out_valid/result got %b/%b/%h required 1/0/0", cur_x, ir(), ov(), res());
      end
    end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_directed_32();
    issue("MUL",    3'd0, 32'd7,        -32'sd3,      32'hFFFF_FFEB); collect();
    issue("MULH",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000); collect();
    issue("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF); collect();
    issue("MULHU",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE); collect();
    issue("DIV",    3'd4, -32'sd7,      32'd2,        32'hFFFF_FFFD); collect();
    issue("REM",    3'd6, -32'sd7,      32'd2,        32'hFFFF_FFFF); collect();
    issue("DIVU",   3'd5, 32'd100,      32'd7,        32'd14);        collect();
    issue("REMU",   3'd7, 32'd100,      32'd7,        32'd2);         collect();
    issue("DIV0",   3'd4, 32'd12345,    32'd0,        32'hFFFF_FFFF); collect();
    issue("REM0",   3'd6, 32'd5,        32'd0,        32'd5);         collect();
    issue("DIVU0",  3'd5, 32'd9,        32'd0,        32'hFFFF_FFFF); collect();
    issue("REMU0",  3'd7, 32'd9,        32'd0,        32'd9);         collect();
    issue("DIVOVF", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000); collect();
    issue("REMOVF", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);         collect();
  endtask

  task automatic test_directed_16();
    issue_m("MUL",    3'd0, 32'd7,     32'hFFFD);
    issue_m("MULH",   3'd1, 32'h8000,  32'h8000);
    issue_m("MULHSU", 3'd2, 32'hFFFF,  32'hFFFF);
    issue_m("MULHU",  3'd3, 32'hFFFF,  32'hFFFF);
    issue_m("DIV",    3'd4, 32'hFFF9,  32'd2);
    issue_m("REM",    3'd6, 32'hFFF9,  32'd2);
    issue_m("DIVU",   3'd5, 32'd100,   32'd7);
    issue_m("REMU",   3'd7, 32'd100,   32'd7);
    issue_m("DIV0",   3'd4, 32'd1234,  32'd0);
    issue_m("REM0",   3'd6, 32'd5,     32'd0);
    issue_m("DIVOVF", 3'd4, 32'h8000,  32'hFFFF);
    issue_m("REMOVF", 3'd6, 32'h8000,  32'hFFFF);
  endtask

  task automatic test_hold();
    logic [31:0] expv;
    int n = 0;
    expv = model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
    start_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
    while (!ov() && n < 200) begin
      @(posedge clock); #1; n++;
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (ov() !== 1'b1 || ir() !== 1'b0 || res() !== expv) begin
        errors++;
        $display("FAIL hold_x%0d cycle %0d: out_valid/in_ready/result got %b/%b/%h required 1/0/%h",
                 cur_x, i, ov(), ir(), res(), expv);
      end
      @(posedge clock); #1;
    end
    $display("x%0d HOLD result=%h", cur_x, res());
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    checks++;
    if (ir() !== 1'b1 || ov() !== 1'b0) begin
      errors++;
      $display("FAIL hold_release_x%0d: in_ready/out_valid got %b/%b required 1/0", cur_x, ir(), ov());
    end
  endtask

  task automatic test_flush();
    logic seen = 1'b0;
    start_op(3'd5, 32'd1000, 32'd3);
    repeat (10) @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    checks++;
    if (ir() !== 1'b1 || ov() !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy_x%0d: in_ready/out_valid got %b/%b required 1/0", cur_x, ir(), ov());
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (ov()) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop_x%0d: out_valid rose got 1 required 0", cur_x);
    end
    $display("x%0d FLUSH busy dropped", cur_x);
    issue_m("MUL_AFTER_FLUSH", 3'd0, 32'h0000_1234, 32'h0000_0567);

    // Flush wins over out_ready: the held result is discarded.
    start_op(3'd4, 32'd5, 32'd0);
    flush = 1'b1;
    out_ready = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (ir() !== 1'b1 || ov() !== 1'b0) begin
      errors++;
      $display("FAIL flush_done_x%0d: in_ready/out_valid got %b/%b required 1/0", cur_x, ir(), ov());
    end

    // Flush wins over in_valid: a divide-by-zero would otherwise reach DONE at once.
    funct3 = 3'd4;
    src1_32 = 32'd7; src2_32 = 32'd0;
    src1_16 = 16'd7; src2_16 = 16'd0;
    if (cur_x == 32) in_valid_32 = 1'b1;
    else             in_valid_16 = 1'b1;
    flush = 1'b1;
    @(posedge clock); #1;
    in_valid_32 = 1'b0;
    in_valid_16 = 1'b0;
    flush = 1'b0;
    checks++;
    if (ir() !== 1'b1 || ov() !== 1'b0) begin
      errors++;
      $display("FAIL flush_accept_x%0d: in_ready/out_valid got %b/%b required 1/0", cur_x, ir(), ov());
    end
  endtask

  task automatic test_reset_mid();
    start_op(3'd5, 32'd50000, 32'd7);
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++;
    if (ir() !== 1'b1 || ov() !== 1'b0 || res() !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_x%0d: in_ready/out_valid/result got %b/%b/%h required 1/0/0", cur_x, ir(), ov(), res());
    end
    $display("x%0d RESET mid-op", cur_x);
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      if (i == 3) a = 32'h0;
      issue("RND", f, a, b, model(f, a, b));
      collect();
    end
  endtask

  task automatic run_width(input int w);
    cur_x = w;
    if (w == 32) test_directed_32();
    else         test_directed_16();
    test_hold();
    test_flush();
    test_reset_mid();
    test_back_to_back();
  endtask

  initial begin
    test_reset();
    run_width(32);
    run_width(16);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
